shift_reg_universal_async_clr: RTL

Parametrised successor to the single-bit negative-edge, async-clear D flip-flop. It is a WIDTH-bit universal register with hold, shift-right, shift-left and parallel-load modes, plus optional rotate. The clock edge is selectable, and an async clear returns the register to a parameterised value. A shift counter and DONE flag let it serve directly as a parallel-to-serial or serial-to-parallel converter in the FlipFlops library.

---
 rtl/shift_reg_universal_async_clr_pkg.sv | 15 +
 rtl/shift_reg_universal_async_clr_cnt.sv | 58 +++++
 rtl/shift_reg_universal_async_clr.sv | 81 ++++++++
 3 files changed

// File: rtl/shift_reg_universal_async_clr_pkg.sv
// Shared definitions for the FlipFlops library shift-register blocks.
// Mode encodings and counter sizing used by the register core and its counters.
package ff_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Bits needed to hold a count of 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_reg_universal_async_clr_cnt.sv
// Saturating shift counter with load-clear and registered DONE flag.
// Edge polarity is selectable so it can sit beside either register flavour.
module shift_cnt_sat
    import ff_pkg::*;
#(
    parameter int MAX      = 8,
    parameter int CNT_W    = cnt_width(MAX),
    parameter bit NEG_EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_next;
    logic             done_next;

    // Load wins over increment so a load on the would-be DONE edge clears it.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt_next = cnt + 1'b1;
        end
        done_next = (cnt_next == CNT_MAX);
    end

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk or posedge clr) begin
                if (clr) begin
                    cnt  <= '0;
                    done <= 1'b0;
                end else begin
                    cnt  <= cnt_next;
                    done <= done_next;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    cnt  <= '0;
                    done <= 1'b0;
                end else begin
                    cnt  <= cnt_next;
                    done <= done_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/shift_reg_universal_async_clr.sv
// Universal WIDTH-bit register: hold / shift right / shift left / load, optional rotate,
// selectable clock edge, async clear to RESET_VALUE, and a saturating shift counter.
module shift_reg_universal_async_clr
    import ff_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter bit               NEG_EDGE    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               ROTATE      = 1'b0,
    parameter int               CNT_W       = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_next;
    logic             fill_r;
    logic             fill_l;
    logic             shift_en;
    logic             load_en;

    // In rotate mode the outgoing bit recirculates instead of the serial input.
    assign fill_r = ROTATE ? q[0]       : sin_r;
    assign fill_l = ROTATE ? q[WIDTH-1] : sin_l;

    always_comb begin
        q_next = q;
        if (en) begin
            case (mode)
                MODE_SHR:  q_next = {fill_r, q[WIDTH-1:1]};
                MODE_SHL:  q_next = {q[WIDTH-2:0], fill_l};
                MODE_LOAD: q_next = d;
                default:   q_next = q;
            endcase
        end
    end

    assign shift_en = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
    assign load_en  = en && (mode == MODE_LOAD);

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk or posedge clr) begin
                if (clr) q <= RESET_VALUE;
                else     q <= q_next;
            end
        end else begin : g_pos
            always_ff @(posedge clk or posedge clr) begin
                if (clr) q <= RESET_VALUE;
                else     q <= q_next;
            end
        end
    endgenerate

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    shift_cnt_sat #(
        .MAX      (WIDTH),
        .CNT_W    (CNT_W),
        .NEG_EDGE (NEG_EDGE)
    ) u_cnt (
        .clk  (clk),
        .clr  (clr),
        .inc  (shift_en),
        .load (load_en),
        .cnt  (shift_cnt),
        .done (done)
    );

endmodule
